// File: rtl/button_conditioner_if.sv
// Button channel bundle: raw push-button inputs toward the conditioner,
// debounced level and single-cycle event pulses back to the consumer.
interface button_conditioner_if #(
  parameter int unsigned N_CH = 4
);
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] btn_press;
  logic [N_CH-1:0] btn_release;
  logic [N_CH-1:0] btn_repeat;

  modport master (
    output btn_in,
    input  btn_level, btn_press, btn_release, btn_repeat
  );

  modport slave (
    input  btn_in,
    output btn_level, btn_press, btn_release, btn_repeat
  );
endinterface

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: two-flop synchroniser, stability
// qualification, press/release pulses and optional hold-to-repeat pulse train.
module button_conditioner #(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned ACTIVE_LOW    = 0,
  parameter int unsigned REPEAT_EN     = 1,
  parameter int unsigned HOLD_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000
) (
  input  logic                clk_in,
  input  logic                rst_in,
  button_conditioner_if.slave btn
);

  localparam int unsigned CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HCNT_W   = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {REL, HOLD, RPT} rpt_state_t;

  logic [N_CH-1:0]   raw;
  logic [N_CH-1:0]   sync0;
  logic [N_CH-1:0]   sync1;
  logic [N_CH-1:0]   level_q;
  logic [N_CH-1:0]   press_q;
  logic [N_CH-1:0]   release_q;
  logic [N_CH-1:0]   repeat_q;
  logic [N_CH-1:0]   accept;
  logic [CNT_W-1:0]  stab_cnt [N_CH];
  logic [HCNT_W-1:0] hold_cnt [N_CH];
  rpt_state_t        state    [N_CH];

  assign raw = (ACTIVE_LOW != 0) ? ~btn.btn_in : btn.btn_in;

  // A channel accepts its synchronised sample once it has disagreed with the
  // current level for STABLE_CYCLES consecutive edges.
  always_comb begin
    accept = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      accept[ch] = (sync1[ch] != level_q[ch]) &&
                   (stab_cnt[ch] == CNT_W'(STABLE_CYCLES - 1));
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync0     <= '0;
      sync1     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      for (int ch = 0; ch < N_CH; ch++) begin
        stab_cnt[ch] <= '0;
        hold_cnt[ch] <= '0;
        state[ch]    <= REL;
      end
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
      for (int ch = 0; ch < N_CH; ch++) begin
        press_q[ch]   <= accept[ch] & sync1[ch];
        release_q[ch] <= accept[ch] & ~sync1[ch];
        repeat_q[ch]  <= 1'b0;

        if (accept[ch]) begin
          level_q[ch] <= sync1[ch];
        end

        if ((sync1[ch] == level_q[ch]) || accept[ch]) begin
          stab_cnt[ch] <= '0;
        end else begin
          stab_cnt[ch] <= stab_cnt[ch] + CNT_W'(1);
        end

        // Repeat engine; an accepted release always wins over a due repeat.
        if (REPEAT_EN == 0) begin
          state[ch]    <= REL;
          hold_cnt[ch] <= '0;
        end else begin
          case (state[ch])
            REL: begin
              if (accept[ch] && sync1[ch]) begin
                state[ch]    <= HOLD;
                hold_cnt[ch] <= HCNT_W'(1);
              end
            end
            HOLD: begin
              if (accept[ch]) begin
                state[ch]    <= REL;
                hold_cnt[ch] <= '0;
              end else if (hold_cnt[ch] == HCNT_W'(HOLD_CYCLES)) begin
                repeat_q[ch] <= 1'b1;
                hold_cnt[ch] <= HCNT_W'(1);
                state[ch]    <= RPT;
              end else begin
                hold_cnt[ch] <= hold_cnt[ch] + HCNT_W'(1);
              end
            end
            RPT: begin
              if (accept[ch]) begin
                state[ch]    <= REL;
                hold_cnt[ch] <= '0;
              end else if (hold_cnt[ch] == HCNT_W'(REPEAT_CYCLES)) begin
                repeat_q[ch] <= 1'b1;
                hold_cnt[ch] <= HCNT_W'(1);
              end else begin
                hold_cnt[ch] <= hold_cnt[ch] + HCNT_W'(1);
              end
            end
            default: begin
              state[ch]    <= REL;
              hold_cnt[ch] <= '0;
            end
          endcase
        end
      end
    end
  end

  assign btn.btn_level   = level_q;
  assign btn.btn_press   = press_q;
  assign btn.btn_release = release_q;
  assign btn.btn_repeat  = repeat_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: instance A is active-high with repeat,
// instance B is active-low with repeat disabled.
module tb_button_conditioner;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   total  = 0;
  int   bad    = 0;

  always #5 clk_in = ~clk_in;

  button_conditioner_if #(.N_CH(2)) bus_a ();
  button_conditioner_if #(.N_CH(2)) bus_b ();

  button_conditioner #(
    .N_CH(2), .STABLE_CYCLES(4), .ACTIVE_LOW(0), .REPEAT_EN(1),
    .HOLD_CYCLES(10), .REPEAT_CYCLES(3)
  ) dut_a (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .btn    (bus_a)
  );

  button_conditioner #(
    .N_CH(2), .STABLE_CYCLES(4), .ACTIVE_LOW(1), .REPEAT_EN(0),
    .HOLD_CYCLES(10), .REPEAT_CYCLES(3)
  ) dut_b (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .btn    (bus_b)
  );

  // Observed {level, press, release, repeat}, two bits each.
  wire [7:0] obs_a = {bus_a.btn_level, bus_a.btn_press, bus_a.btn_release, bus_a.btn_repeat};
  wire [7:0] obs_b = {bus_b.btn_level, bus_b.btn_press, bus_b.btn_release, bus_b.btn_repeat};

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    logic [1:0] e_lvl, e_prs, e_rel;
    rst_in = 1'b1;
    bus_a.btn_in = 2'b11;
    repeat (3) step();
    total++;
    if (obs_a !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=%b", obs_a, 8'h00);
    end
    rst_in = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      e_lvl = (k >= 6) ? 2'b11 : 2'b00;
      e_prs = (k == 6) ? 2'b11 : 2'b00;
      total++;
      if (obs_a !== {e_lvl, e_prs, 2'b00, 2'b00}) begin
        bad++;
        $display("FAIL reset_exit_press k=%0d got=%b exp=%b", k, obs_a, {e_lvl, e_prs, 4'b0000});
      end
    end
    bus_a.btn_in = 2'b00;
    for (int k = 1; k <= 7; k++) begin
      step();
      e_lvl = (k >= 6) ? 2'b00 : 2'b11;
      e_rel = (k == 6) ? 2'b11 : 2'b00;
      total++;
      if (obs_a !== {e_lvl, 2'b00, e_rel, 2'b00}) begin
        bad++;
        $display("FAIL reset_exit_release k=%0d got=%b exp=%b", k, obs_a, {e_lvl, 2'b00, e_rel, 2'b00});
      end
    end
  endtask

  task automatic test_glitch();
    logic [1:0] e_lvl, e_prs, e_rel;
    bus_a.btn_in = 2'b01;
    repeat (3) step();
    bus_a.btn_in = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      step();
      total++;
      if (obs_a !== 8'h00) begin
        bad++;
        $display("FAIL glitch_short k=%0d got=%b exp=%b", k, obs_a, 8'h00);
      end
    end
    // Four high samples are just enough; the fall is first sampled on edge 5.
    bus_a.btn_in = 2'b01;
    repeat (4) step();
    bus_a.btn_in = 2'b00;
    for (int k = 5; k <= 11; k++) begin
      step();
      e_lvl = (k >= 6 && k < 10) ? 2'b01 : 2'b00;
      e_prs = (k == 6) ? 2'b01 : 2'b00;
      e_rel = (k == 10) ? 2'b01 : 2'b00;
      total++;
      if (obs_a !== {e_lvl, e_prs, e_rel, 2'b00}) begin
        bad++;
        $display("FAIL glitch_exact k=%0d got=%b exp=%b", k, obs_a, {e_lvl, e_prs, e_rel, 2'b00});
      end
    end
  endtask

  task automatic test_hold_repeat();
    logic [1:0] e_rel, e_rpt;
    bus_a.btn_in = 2'b10;
    repeat (6) step();
    total++;
    if (obs_a !== {2'b10, 2'b10, 2'b00, 2'b00}) begin
      bad++;
      $display("FAIL hold_press got=%b exp=%b", obs_a, {2'b10, 2'b10, 4'b0000});
    end
    // j counts edges after the press pulse P; input held for 30 samples total.
    for (int j = 1; j <= 40; j++) begin
      step();
      if (j == 24) bus_a.btn_in = 2'b00;
      e_rpt = (j >= 10 && j < 30 && ((j - 10) % 3) == 0) ? 2'b10 : 2'b00;
      e_rel = (j == 30) ? 2'b10 : 2'b00;
      total++;
      if (obs_a[5:0] !== {2'b00, e_rel, e_rpt}) begin
        bad++;
        $display("FAIL hold_repeat P+%0d got=%b exp=%b", j, obs_a[5:0], {2'b00, e_rel, e_rpt});
      end
    end
  endtask

  task automatic test_channel_independence();
    logic [1:0] e_lvl, e_prs, e_rel;
    bus_a.btn_in = 2'b10;
    repeat (8) step();
    bus_a.btn_in = 2'b01;
    for (int k = 1; k <= 7; k++) begin
      step();
      e_lvl = (k >= 6) ? 2'b01 : 2'b10;
      e_prs = (k == 6) ? 2'b01 : 2'b00;
      e_rel = (k == 6) ? 2'b10 : 2'b00;
      total++;
      if (obs_a[7:2] !== {e_lvl, e_prs, e_rel}) begin
        bad++;
        $display("FAIL chan_indep k=%0d got=%b exp=%b", k, obs_a[7:2], {e_lvl, e_prs, e_rel});
      end
    end
    bus_a.btn_in = 2'b00;
    repeat (7) step();
  endtask

  task automatic test_reset_mid_hold();
    logic [1:0] e_lvl, e_prs;
    bus_a.btn_in = 2'b01;
    repeat (6) step();
    total++;
    if (bus_a.btn_press !== 2'b01) begin
      bad++;
      $display("FAIL midhold_press got=%b exp=%b", bus_a.btn_press, 2'b01);
    end
    repeat (4) step();
    rst_in = 1'b1;
    step();
    total++;
    if (obs_a !== 8'h00) begin
      bad++;
      $display("FAIL midhold_reset got=%b exp=%b", obs_a, 8'h00);
    end
    rst_in = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      e_lvl = (k >= 6) ? 2'b01 : 2'b00;
      e_prs = (k == 6) ? 2'b01 : 2'b00;
      total++;
      if (obs_a !== {e_lvl, e_prs, 2'b00, 2'b00}) begin
        bad++;
        $display("FAIL midhold_fresh k=%0d got=%b exp=%b", k, obs_a, {e_lvl, e_prs, 4'b0000});
      end
    end
    bus_a.btn_in = 2'b00;
    repeat (7) step();
  endtask

  task automatic test_active_low_no_repeat();
    logic [1:0] e_lvl, e_prs;
    total++;
    if (obs_b !== 8'h00) begin
      bad++;
      $display("FAIL al_idle got=%b exp=%b", obs_b, 8'h00);
    end
    bus_b.btn_in = 2'b10;
    for (int k = 1; k <= 6; k++) begin
      step();
      e_lvl = (k >= 6) ? 2'b01 : 2'b00;
      e_prs = (k == 6) ? 2'b01 : 2'b00;
      total++;
      if (obs_b !== {e_lvl, e_prs, 2'b00, 2'b00}) begin
        bad++;
        $display("FAIL al_press k=%0d got=%b exp=%b", k, obs_b, {e_lvl, e_prs, 4'b0000});
      end
    end
    for (int j = 1; j <= 40; j++) begin
      step();
      total++;
      if (obs_b !== {2'b01, 6'b000000}) begin
        bad++;
        $display("FAIL al_no_repeat P+%0d got=%b exp=%b", j, obs_b, {2'b01, 6'b000000});
      end
    end
  endtask

  initial begin
    bus_a.btn_in = 2'b00;
    bus_b.btn_in = 2'b11;
    test_reset();
    test_glitch();
    test_hold_repeat();
    test_channel_independence();
    test_reset_mid_hold();
    test_active_low_no_repeat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
